frame_scroll_ctrl: RTL and testbench

FRAME_SCROLL_CTRL -- requirements
Module: frame_scroll_ctrl

---
 rtl/frame_scroll_ctrl_pkg.sv | 37 +++
 rtl/frame_scroll_ctrl_if.sv | 28 ++
 rtl/frame_scroll_ctrl_scroll_seq.sv | 89 ++++++++
 rtl/frame_scroll_ctrl.sv | 132 +++++++++++++
 tb/tb_frame_scroll_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/frame_scroll_ctrl_pkg.sv
// Shared display definitions for the frame scroll controller.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
// Holds the source-mode encodings, per-mode width/height/shift constants
// and the scroll sequencer state type.
package frame_scroll_ctrl_pkg;

   // Source image scale selected by mode_sel.
   typedef enum logic {
      MODE_DIV2 = 1'b0,   // 320x240 source, screen coords >> 1
      MODE_DIV4 = 1'b1    // 160x120 source, screen coords >> 2
   } mode_e;

   localparam int unsigned M0_W     = 320;
   localparam int unsigned M0_H     = 240;
   localparam int unsigned M0_SHIFT = 1;
   localparam int unsigned M1_W     = 160;
   localparam int unsigned M1_H     = 120;
   localparam int unsigned M1_SHIFT = 2;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_COUNT = 2'd1,
      SEQ_STEP  = 2'd2
   } seq_state_e;

   // Source height in rows for a mode.
   function automatic logic [8:0] mode_h(input mode_e m);
      return (m == MODE_DIV4) ? 9'(M1_H) : 9'(M0_H);
   endfunction

   // Last valid source row for a mode (scroll wrap point).
   function automatic logic [7:0] mode_h_max(input mode_e m);
      return (m == MODE_DIV4) ? 8'(M1_H - 1) : 8'(M0_H - 1);
   endfunction

endpackage

// File: rtl/frame_scroll_ctrl_if.sv
// Bundle of VGA counters, scroll controls and frame-buffer address outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the display timing free-runs.
// master: drives h_cnt/v_cnt and the scroll controls, observes the results.
// slave : the controller; consumes counters/controls, produces address,
//         valid, scroll position and frame tick.
interface frame_scroll_ctrl_if;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        mode_sel;
   logic        scroll_en;
   logic        scroll_dir;
   logic [3:0]  speed;
   logic [16:0] pixel_addr;
   logic        addr_valid;
   logic [7:0]  position;
   logic        frame_tick;

   modport master (
      output h_cnt, v_cnt, mode_sel, scroll_en, scroll_dir, speed,
      input  pixel_addr, addr_valid, position, frame_tick
   );

   modport slave (
      input  h_cnt, v_cnt, mode_sel, scroll_en, scroll_dir, speed,
      output pixel_addr, addr_valid, position, frame_tick
   );
endinterface

// File: rtl/frame_scroll_ctrl_scroll_seq.sv
// Scroll sequencer: frame divider and vertical scroll position register.
// Latency: position updates at the end of the one-cycle STEP state, i.e. two
//          clocks after the frame tick that triggers the step.
// Backpressure: none; advances only on frame ticks.
// Ports: clk/rst; i_tick frame boundary pulse; i_en/i_speed controls as seen
//        on this cycle (fresh values on a tick); i_dir latched direction;
//        i_mode_chg mode switch on this tick; i_h_max last source row;
//        o_position current scroll offset.
module scroll_seq
   import frame_scroll_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       i_en,
   input  logic [3:0] i_speed,
   input  logic       i_dir,
   input  logic       i_mode_chg,
   input  logic [7:0] i_h_max,
   output logic [7:0] o_position
);

   seq_state_e r_state;
   seq_state_e w_state_nxt;
   logic [3:0] r_div;
   logic [3:0] w_div_nxt;
   logic [3:0] w_div_last;
   logic [7:0] r_pos;
   logic [7:0] w_pos_nxt;

   // A speed of 0 behaves as 1: step on every frame.
   assign w_div_last = (i_speed == 4'd0) ? 4'd0 : i_speed - 4'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SEQ_IDLE;
         r_div   <= 4'd0;
         r_pos   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_pos   <= w_pos_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_pos_nxt   = r_pos;

      if (r_state == SEQ_STEP) begin
         w_state_nxt = SEQ_COUNT;
         if (i_dir == 1'b0)
            w_pos_nxt = (r_pos == i_h_max) ? 8'd0 : r_pos + 8'd1;
         else
            w_pos_nxt = (r_pos == 8'd0) ? i_h_max : r_pos - 8'd1;
      end

      if (i_tick) begin
         if (!i_en) begin
            w_state_nxt = SEQ_IDLE;
         end else begin
            case (r_state)
               SEQ_IDLE:  w_state_nxt = SEQ_COUNT;
               SEQ_COUNT: begin
                  // A mode switch restarts the divider without stepping.
                  if (!i_mode_chg) begin
                     if (r_div == w_div_last) begin
                        w_state_nxt = SEQ_STEP;
                        w_div_nxt   = 4'd0;
                     end else begin
                        w_div_nxt   = r_div + 4'd1;
                     end
                  end
               end
               default:   w_state_nxt = SEQ_COUNT;
            endcase
         end
         // Old offset is meaningless in the new geometry; clear wins over a step.
         if (i_mode_chg) begin
            w_pos_nxt = 8'd0;
            w_div_nxt = 4'd0;
         end
      end
   end

   assign o_position = r_pos;

endmodule

// File: rtl/frame_scroll_ctrl.sv
// Frame-buffer address generator with vertical scrolling for a 2x/4x upscaled VGA image.
// Latency: pixel_addr/addr_valid one clock after h_cnt/v_cnt; frame_tick combinational.
// Backpressure: none; follows the free-running VGA counters.
// Ports: clk, rst (sync, active high); bus (slave modport): h_cnt/v_cnt,
//        mode_sel, scroll_en, scroll_dir, speed in; pixel_addr, addr_valid,
//        position, frame_tick out.
module frame_scroll_ctrl
   import frame_scroll_ctrl_pkg::*;
#(
   parameter int unsigned FRAME_LINE = 480,
   parameter int unsigned ACT_W      = 640,
   parameter int unsigned ACT_H      = 480
)
(
   input  logic                 clk,
   input  logic                 rst,
   frame_scroll_ctrl_if.slave   bus
);

   localparam logic [10:0] LP_FRAME_LINE = 11'(FRAME_LINE);
   localparam logic [10:0] LP_ACT_W      = 11'(ACT_W);
   localparam logic [10:0] LP_ACT_H      = 11'(ACT_H);

   // Frame edge detect; the history bit makes the tick independent of how
   // many clocks v_cnt dwells on the frame line.
   logic r_at_line;
   logic w_at_line;
   logic w_tick;

   assign w_at_line = ({1'b0, bus.v_cnt} == LP_FRAME_LINE);
   assign w_tick    = w_at_line & ~r_at_line & ~rst;

   always_ff @(posedge clk) begin
      if (rst) r_at_line <= 1'b0;
      else     r_at_line <= w_at_line;
   end

   // Controls latched once per frame.
   mode_e      r_mode;
   logic       r_en;
   logic       r_dir;
   logic [3:0] r_speed;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode  <= MODE_DIV2;
         r_en    <= 1'b0;
         r_dir   <= 1'b0;
         r_speed <= 4'd0;
      end else if (w_tick) begin
         r_mode  <= mode_e'(bus.mode_sel);
         r_en    <= bus.scroll_en;
         r_dir   <= bus.scroll_dir;
         r_speed <= bus.speed;
      end
   end

   // On a tick the sequencer acts on the values being latched this cycle.
   logic       w_mode_chg;
   logic       w_en_eff;
   logic [3:0] w_speed_eff;
   logic [7:0] w_position;

   assign w_mode_chg  = w_tick & (mode_e'(bus.mode_sel) != r_mode);
   assign w_en_eff    = w_tick ? bus.scroll_en : r_en;
   assign w_speed_eff = w_tick ? bus.speed : r_speed;

   scroll_seq u_seq (
      .clk        (clk),
      .rst        (rst),
      .i_tick     (w_tick),
      .i_en       (w_en_eff),
      .i_speed    (w_speed_eff),
      .i_dir      (r_dir),
      .i_mode_chg (w_mode_chg),
      .i_h_max    (mode_h_max(r_mode)),
      .o_position (w_position)
   );

   // Address arithmetic uses the registered position, so a step shows up
   // in addresses from the cycle after the STEP state.
   logic [9:0]  w_sx;
   logic [9:0]  w_sy;
   logic [8:0]  w_h;
   logic [10:0] w_row_sum;
   logic [10:0] w_row;
   logic [16:0] w_row17;
   logic [16:0] w_row_x_w;
   logic [16:0] w_addr;
   logic        w_active;

   always_comb begin
      w_h = mode_h(r_mode);
      if (r_mode == MODE_DIV4) begin
         w_sx = bus.h_cnt >> M1_SHIFT;
         w_sy = bus.v_cnt >> M1_SHIFT;
      end else begin
         w_sx = bus.h_cnt >> M0_SHIFT;
         w_sy = bus.v_cnt >> M0_SHIFT;
      end
   end

   // Both addends are below H inside the active area, so one subtract wraps.
   assign w_row_sum = {1'b0, w_sy} + {3'b000, w_position};
   assign w_row     = (w_row_sum >= {2'b00, w_h}) ? w_row_sum - {2'b00, w_h} : w_row_sum;
   assign w_row17   = {6'd0, w_row};

   // row*320 = row*256 + row*64; row*160 = row*128 + row*32.
   assign w_row_x_w = (r_mode == MODE_DIV4) ? (w_row17 << 7) + (w_row17 << 5)
                                            : (w_row17 << 8) + (w_row17 << 6);
   assign w_addr    = w_row_x_w + {7'd0, w_sx};
   assign w_active  = ({1'b0, bus.h_cnt} < LP_ACT_W) && ({1'b0, bus.v_cnt} < LP_ACT_H);

   logic [16:0] r_pixel_addr;
   logic        r_addr_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pixel_addr <= 17'd0;
         r_addr_valid <= 1'b0;
      end else begin
         r_pixel_addr <= w_active ? w_addr : 17'd0;
         r_addr_valid <= w_active;
      end
   end

   assign bus.pixel_addr = r_pixel_addr;
   assign bus.addr_valid = r_addr_valid;
   assign bus.position   = w_position;
   assign bus.frame_tick = w_tick;

endmodule

// File: tb/tb_frame_scroll_ctrl.sv
// Directed bench for frame_scroll_ctrl: address mapping, scroll sequencing,
// frame tick edge detection and reset behaviour, with hand-computed expectations.
module tb_frame_scroll_ctrl;
   import frame_scroll_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   pulses;

   frame_scroll_ctrl_if bus_if ();

   frame_scroll_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One frame boundary: v_cnt on the frame line for a cycle, then back to 0.
   task automatic frame();
      bus_if.v_cnt = 10'd480;
      step();
      bus_if.v_cnt = 10'd0;
      step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus_if.h_cnt      = 10'd0;
      bus_if.v_cnt      = 10'd0;
      bus_if.mode_sel   = 1'b0;
      bus_if.scroll_en  = 1'b0;
      bus_if.scroll_dir = 1'b0;
      bus_if.speed      = 4'd0;

      // Reset state
      step(); step(); step();
      chk("rst_addr",  bus_if.pixel_addr, 0);
      chk("rst_valid", bus_if.addr_valid, 0);
      chk("rst_pos",   bus_if.position, 0);
      chk("rst_state", dut.u_seq.r_state, SEQ_IDLE);
      bus_if.v_cnt = 10'd480;
      #1;
      chk("rst_tick_gated", bus_if.frame_tick, 0);
      step();
      bus_if.v_cnt = 10'd0;
      rst = 1'b0;
      step();

      // Mode 0, no scroll: h=10,v=20 -> 5 + 10*320
      bus_if.h_cnt = 10'd10;
      bus_if.v_cnt = 10'd20;
      #1;
      chk("latency_old_addr", bus_if.pixel_addr, 0);
      step();
      chk("m0_addr",  bus_if.pixel_addr, 3205);
      chk("m0_valid", bus_if.addr_valid, 1);
      bus_if.h_cnt = 10'd639;
      bus_if.v_cnt = 10'd479;
      step();
      chk("m0_max_addr", bus_if.pixel_addr, 76799);

      // Outside active area
      bus_if.h_cnt = 10'd640;
      bus_if.v_cnt = 10'd20;
      step();
      chk("h640_valid", bus_if.addr_valid, 0);
      chk("h640_addr",  bus_if.pixel_addr, 0);
      bus_if.h_cnt = 10'd10;
      bus_if.v_cnt = 10'd480;
      #1;
      chk("tick_on_line", bus_if.frame_tick, 1);
      step();
      chk("v480_valid", bus_if.addr_valid, 0);
      chk("v480_addr",  bus_if.pixel_addr, 0);
      bus_if.v_cnt = 10'd481;
      step();

      // Long dwell on the frame line: exactly one pulse
      pulses = 0;
      bus_if.v_cnt = 10'd480;
      for (int i = 0; i < 3200; i++) begin
         #1;
         if (bus_if.frame_tick === 1'b1) pulses++;
         step();
      end
      chk("dwell_pulses", pulses, 1);
      bus_if.v_cnt = 10'd0;
      step();

      // Mode 1, scroll up speed 1; first tick switches mode (no step)
      bus_if.mode_sel  = 1'b1;
      bus_if.scroll_en = 1'b1;
      bus_if.speed     = 4'd1;
      frame();
      chk("modechg_pos",   bus_if.position, 0);
      chk("modechg_state", dut.u_seq.r_state, SEQ_COUNT);
      frame();
      chk("m1_first_step", bus_if.position, 1);
      for (int i = 0; i < 99; i++) frame();
      chk("m1_pos100", bus_if.position, 100);

      // Mode 1 addressing with position 100
      bus_if.h_cnt = 10'd639;
      bus_if.v_cnt = 10'd479;
      step();
      chk("m1_wrap_addr", bus_if.pixel_addr, 15999);
      // Mid-frame control change must not affect this frame: 1 + 102*160
      bus_if.mode_sel   = 1'b0;
      bus_if.scroll_dir = 1'b1;
      bus_if.speed      = 4'd0;
      bus_if.h_cnt      = 10'd4;
      bus_if.v_cnt      = 10'd8;
      step();
      chk("midframe_addr", bus_if.pixel_addr, 16321);
      chk("midframe_pos",  bus_if.position, 100);
      frame();
      chk("m0_switch_pos", bus_if.position, 0);
      frame();
      chk("down_wrap_pos", bus_if.position, 239);

      // Up, speed 3, from 239
      bus_if.scroll_dir = 1'b0;
      bus_if.speed      = 4'd3;
      frame();
      frame();
      chk("spd3_hold", bus_if.position, 239);
      frame();
      chk("spd3_wrap", bus_if.position, 0);
      frame();
      frame();
      chk("spd3_stay0", bus_if.position, 0);
      frame();
      chk("spd3_next", bus_if.position, 1);

      // Mode 0 addressing with position 1
      bus_if.h_cnt = 10'd10;
      bus_if.v_cnt = 10'd20;
      step();
      chk("m0_pos1_addr", bus_if.pixel_addr, 3525);
      bus_if.h_cnt = 10'd0;
      bus_if.v_cnt = 10'd479;
      step();
      chk("m0_rowwrap_addr",  bus_if.pixel_addr, 0);
      chk("m0_rowwrap_valid", bus_if.addr_valid, 1);

      // Disable: IDLE, position held
      bus_if.scroll_en = 1'b0;
      frame();
      chk("dis_state", dut.u_seq.r_state, SEQ_IDLE);
      frame();
      chk("dis_pos", bus_if.position, 1);

      // Reset during STEP
      bus_if.scroll_en = 1'b1;
      bus_if.speed     = 4'd1;
      frame();
      bus_if.v_cnt = 10'd480;
      step();
      chk("in_step", dut.u_seq.r_state, SEQ_STEP);
      rst = 1'b1;
      bus_if.v_cnt = 10'd0;
      step();
      chk("rst_step_pos",   bus_if.position, 0);
      chk("rst_step_state", dut.u_seq.r_state, SEQ_IDLE);
      rst = 1'b0;
      step();
      step();
      chk("no_pending_step", bus_if.position, 0);
      frame();
      chk("relatch_state", dut.u_seq.r_state, SEQ_COUNT);
      chk("relatch_pos",   bus_if.position, 0);
      frame();
      chk("relatch_step", bus_if.position, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
